// File: rtl/spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_slave
// Purpose  : SPI slave with register-file access. Pins are oversampled in the clk domain.
//            Optional burst auto-increment is enabled by defining SPI_AUTOINC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_slave #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter bit CPOL   = 1'b0,
    parameter bit CPHA   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              en,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata
);
    localparam int c_CMD_W = 1 + ADDR_W;
    localparam int c_MAX_W = (c_CMD_W > DATA_W) ? c_CMD_W : DATA_W;
    localparam int c_CNT_W = $clog2(c_MAX_W + 1);
    localparam logic [c_CNT_W-1:0] c_CMD_LAST  = c_CNT_W'(c_CMD_W - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_RDREQ = 3'd2,
        S_RDCAP = 3'd3,
        S_DATA  = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;

    // [0],[1] synchroniser flops, [2] previous value for edge detection
    logic [2:0]         r_sclk_sync;
    logic [2:0]         r_en_sync;
    logic [1:0]         r_mosi_sync;
    logic [1:0]         r_sync_cnt;
    logic               r_armed;

    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [c_CMD_W-2:0] r_cmd_sr;
    logic [DATA_W-2:0]  r_rx_sr;
    logic [DATA_W-1:0]  r_tx_sr;
    logic               r_rw;
    logic               r_rd_phase;
    logic               r_done;

    logic               w_sclk_rise, w_sclk_fall, w_lead, w_trail;
    logic               w_sample, w_shift;
    logic               w_en_fall, w_en_rise;
    logic               w_mosi;
    logic               w_cmd_last, w_data_last, w_word_done;
    logic [c_CMD_W-1:0] w_cmd_word;
    logic [DATA_W-1:0]  w_rx_word;

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_lead      = (CPOL == 1'b0) ? w_sclk_rise : w_sclk_fall;
    assign w_trail     = (CPOL == 1'b0) ? w_sclk_fall : w_sclk_rise;
    assign w_sample    = (CPHA == 1'b0) ? w_lead : w_trail;
    assign w_shift     = (CPHA == 1'b0) ? w_trail : w_lead;

    // A frame may only start once en has been seen high from the pin after reset,
    // so a reset in the middle of a frame cannot resynchronise onto its tail.
    assign w_en_fall   = r_armed & r_en_sync[2] & ~r_en_sync[1];
    assign w_en_rise   = ~r_en_sync[2] & r_en_sync[1];
    assign w_mosi      = r_mosi_sync[1];

    assign w_cmd_word  = {r_cmd_sr, w_mosi};
    assign w_rx_word   = {r_rx_sr, w_mosi};
    assign w_cmd_last  = (r_bit_cnt == c_CMD_LAST);
    assign w_data_last = (r_bit_cnt == c_DATA_LAST);
    assign w_word_done = (r_state == S_DATA) && w_sample && w_data_last && !r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_en_fall) w_state_nxt = S_CMD;
            end
            S_CMD: begin
                if (w_sample && w_cmd_last)
                    w_state_nxt = w_cmd_word[c_CMD_W-1] ? S_DATA : S_RDREQ;
            end
            S_RDREQ: w_state_nxt = S_RDCAP;
            S_RDCAP: w_state_nxt = S_DATA;
            S_DATA: begin
`ifdef SPI_AUTOINC_EN
                if (w_word_done && !r_rw) w_state_nxt = S_RDREQ;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if ((r_state != S_IDLE) && w_en_rise) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= {3{CPOL}};
            r_en_sync   <= 3'b111;
            r_mosi_sync <= 2'b00;
            r_sync_cnt  <= 2'd0;
            r_armed     <= 1'b0;
            r_bit_cnt   <= '0;
            r_cmd_sr    <= '0;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_rw        <= 1'b0;
            r_rd_phase  <= 1'b0;
            r_done      <= 1'b0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], sclk};
            r_en_sync   <= {r_en_sync[1:0], en};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
            if (r_sync_cnt != 2'd2) r_sync_cnt <= r_sync_cnt + 2'd1;
            if ((r_sync_cnt == 2'd2) && r_en_sync[1]) r_armed <= 1'b1;

            reg_we  <= w_word_done && r_rw;
            reg_re  <= (w_state_nxt == S_RDREQ);
            miso_oe <= (w_state_nxt != S_IDLE);

`ifdef SPI_AUTOINC_EN
            if (reg_we) reg_addr <= reg_addr + 1'b1;
`endif

            case (r_state)
                S_IDLE: begin
                    if (w_en_fall) begin
                        r_bit_cnt  <= '0;
                        r_cmd_sr   <= '0;
                        r_tx_sr    <= '0;
                        r_rd_phase <= 1'b0;
                        r_done     <= 1'b0;
                        miso       <= 1'b0;
                    end
                end
                S_CMD: begin
                    if (w_sample) begin
                        r_cmd_sr <= w_cmd_word[c_CMD_W-2:0];
                        if (w_cmd_last) begin
                            r_bit_cnt <= '0;
                            reg_addr  <= w_cmd_word[ADDR_W-1:0];
                            r_rw      <= w_cmd_word[c_CMD_W-1];
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_RDCAP: begin
                    r_rd_phase <= 1'b1;
                    r_bit_cnt  <= '0;
                    // CPHA=0 masters sample before any shift edge, so the MSB goes out now
                    if (CPHA == 1'b0) begin
                        {miso, r_tx_sr} <= {reg_rdata, 1'b0};
                    end else begin
                        r_tx_sr <= reg_rdata;
                    end
                end
                S_DATA: begin
                    if (w_shift && r_rd_phase && ((CPHA != 1'b0) || (r_bit_cnt != '0)))
                        {miso, r_tx_sr} <= {r_tx_sr, 1'b0};
                    if (w_sample && !r_done) begin
                        r_rx_sr <= w_rx_word[DATA_W-2:0];
                        if (w_data_last) begin
                            r_bit_cnt <= '0;
                            if (r_rw) reg_wdata <= w_rx_word;
`ifdef SPI_AUTOINC_EN
                            if (!r_rw) reg_addr <= reg_addr + 1'b1;
`else
                            r_done     <= 1'b1;
                            r_rd_phase <= 1'b0;
                            miso       <= 1'b0;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (w_state_nxt == S_IDLE) begin
                miso       <= 1'b0;
                r_rd_phase <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_slave
// Purpose  : Directed bench for spi_reg_slave in SPI modes 0, 1 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_slave;
    localparam int H = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk [3];
    logic       en   [3];
    logic       mosi [3];
    logic       miso [3];
    logic       oe   [3];
    logic       we   [3];
    logic       re   [3];
    logic [6:0] addr [3];
    logic [7:0] wdata[3];
    logic [7:0] rdata[3];

    bit cpol_t[3] = '{1'b0, 1'b0, 1'b1};
    bit cpha_t[3] = '{1'b0, 1'b1, 1'b1};

    int n_checks = 0;
    int n_errors = 0;

    int         we_n[3];
    int         re_n[3];
    logic [6:0] we_a[3][16];
    logic [7:0] we_d[3][16];
    logic [6:0] re_a[3][16];

    always #5 clk = ~clk;

    spi_reg_slave #(.DATA_W(8), .ADDR_W(7), .CPOL(1'b0), .CPHA(1'b0)) u_m0 (
        .clk(clk), .rst(rst), .sclk(sclk[0]), .en(en[0]), .mosi(mosi[0]),
        .miso(miso[0]), .miso_oe(oe[0]), .reg_addr(addr[0]), .reg_wdata(wdata[0]),
        .reg_we(we[0]), .reg_re(re[0]), .reg_rdata(rdata[0]));

    spi_reg_slave #(.DATA_W(8), .ADDR_W(7), .CPOL(1'b0), .CPHA(1'b1)) u_m1 (
        .clk(clk), .rst(rst), .sclk(sclk[1]), .en(en[1]), .mosi(mosi[1]),
        .miso(miso[1]), .miso_oe(oe[1]), .reg_addr(addr[1]), .reg_wdata(wdata[1]),
        .reg_we(we[1]), .reg_re(re[1]), .reg_rdata(rdata[1]));

    spi_reg_slave #(.DATA_W(8), .ADDR_W(7), .CPOL(1'b1), .CPHA(1'b1)) u_m3 (
        .clk(clk), .rst(rst), .sclk(sclk[2]), .en(en[2]), .mosi(mosi[2]),
        .miso(miso[2]), .miso_oe(oe[2]), .reg_addr(addr[2]), .reg_wdata(wdata[2]),
        .reg_we(we[2]), .reg_re(re[2]), .reg_rdata(rdata[2]));

    // Register file model: read data is valid only in the cycle after reg_re
    always @(posedge clk) begin
        for (int m = 0; m < 3; m++) rdata[m] <= re[m] ? 8'h3C : 8'hFF;
    end

    always @(negedge clk) begin
        for (int m = 0; m < 3; m++) begin
            if (we[m]) begin
                if (we_n[m] < 16) begin
                    we_a[m][we_n[m]] = addr[m];
                    we_d[m][we_n[m]] = wdata[m];
                end
                we_n[m]++;
            end
            if (re[m]) begin
                if (re_n[m] < 16) re_a[m][re_n[m]] = addr[m];
                re_n[m]++;
            end
        end
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fbegin(input int m);
        en[m] = 1'b0;
        tick(H);
    endtask

    task automatic fend(input int m);
        tick(H);
        en[m] = 1'b1;
        tick(2 * H);
    endtask

    // Shifts tx[nb-1:0] MSB first; end_last raises en on the final sample edge (CPHA=0 only)
    task automatic xfer(input int m, input logic [7:0] tx, input int nb, input bit end_last,
                        output logic [7:0] rx);
        rx = 8'h00;
        for (int i = nb - 1; i >= 0; i--) begin
            if (!cpha_t[m]) begin
                mosi[m] = tx[i];
                tick(H);
                sclk[m] = ~cpol_t[m];
                rx[i]   = miso[m];
                if (end_last && (i == 0)) en[m] = 1'b1;
                tick(H);
                sclk[m] = cpol_t[m];
            end else begin
                sclk[m] = ~cpol_t[m];
                mosi[m] = tx[i];
                tick(H);
                sclk[m] = cpol_t[m];
                rx[i]   = miso[m];
                tick(H);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        int b, rb;

        rst = 1'b1;
        for (int m = 0; m < 3; m++) begin
            en[m]   = 1'b1;
            mosi[m] = 1'b0;
            sclk[m] = cpol_t[m];
        end
        tick(4);
        chk_val("rst_oe",    oe[0],    0);
        chk_val("rst_miso",  miso[0],  0);
        chk_val("rst_we",    we[0],    0);
        chk_val("rst_re",    re[0],    0);
        chk_val("rst_addr",  addr[0],  0);
        chk_val("rst_wdata", wdata[0], 0);
        chk_val("rst_oe_m3", oe[2],    0);
        rst = 1'b0;
        tick(6);

        // Mode 0 write 0x85 / 0xA5
        b = we_n[0]; rb = re_n[0];
        fbegin(0);
        chk_val("t1_oe_active", oe[0], 1);
        xfer(0, 8'h85, 8, 1'b0, rx);
        chk_val("t1_miso_cmd", rx, 0);
        xfer(0, 8'hA5, 8, 1'b0, rx);
        fend(0);
        chk_val("t1_oe_idle", oe[0], 0);
        chk_val("t1_we_cnt", we_n[0] - b, 1);
        chk_val("t1_we_addr", we_a[0][b], 7'h05);
        chk_val("t1_we_data", we_d[0][b], 8'hA5);
        chk_val("t1_re_cnt", re_n[0] - rb, 0);

        // Mode 3 read of 0x12
        b = we_n[2]; rb = re_n[2];
        fbegin(2);
        xfer(2, 8'h12, 8, 1'b0, rx);
        chk_val("t2_miso_cmd", rx, 0);
        xfer(2, 8'h00, 8, 1'b0, rx);
        chk_val("t2_miso_data", rx, 8'h3C);
        fend(2);
`ifdef SPI_AUTOINC_EN
        chk_val("t2_re_cnt", re_n[2] - rb, 2);
`else
        chk_val("t2_re_cnt", re_n[2] - rb, 1);
`endif
        chk_val("t2_re_addr", re_a[2][rb], 7'h12);
        chk_val("t2_we_cnt", we_n[2] - b, 0);
        chk_val("t2_miso_idle", miso[2], 0);

        // Abort after 5 data bits, then a normal frame
        b = we_n[0];
        fbegin(0);
        xfer(0, 8'h81, 8, 1'b0, rx);
        xfer(0, 8'h1F, 5, 1'b0, rx);
        fend(0);
        chk_val("t3_abort_we", we_n[0] - b, 0);
        fbegin(0);
        xfer(0, 8'h83, 8, 1'b0, rx);
        xfer(0, 8'h5A, 8, 1'b0, rx);
        fend(0);
        chk_val("t3_next_we", we_n[0] - b, 1);
        chk_val("t3_next_addr", we_a[0][b], 7'h03);
        chk_val("t3_next_data", we_d[0][b], 8'h5A);

        // en rises together with the last sample edge: word still completes
        b = we_n[0];
        fbegin(0);
        xfer(0, 8'h84, 8, 1'b0, rx);
        xfer(0, 8'h77, 8, 1'b1, rx);
        tick(2 * H);
        chk_val("t4_we_cnt", we_n[0] - b, 1);
        chk_val("t4_we_addr", we_a[0][b], 7'h04);
        chk_val("t4_we_data", we_d[0][b], 8'h77);

        // Write burst at 0x7F
        b = we_n[0];
        fbegin(0);
        xfer(0, 8'hFF, 8, 1'b0, rx);
        xfer(0, 8'h11, 8, 1'b0, rx);
        xfer(0, 8'h22, 8, 1'b0, rx);
        xfer(0, 8'h33, 8, 1'b0, rx);
        fend(0);
        chk_val("t5_addr0", we_a[0][b], 7'h7F);
        chk_val("t5_data0", we_d[0][b], 8'h11);
`ifdef SPI_AUTOINC_EN
        chk_val("t5_we_cnt", we_n[0] - b, 3);
        chk_val("t5_addr1", we_a[0][b+1], 7'h00);
        chk_val("t5_data1", we_d[0][b+1], 8'h22);
        chk_val("t5_addr2", we_a[0][b+2], 7'h01);
        chk_val("t5_data2", we_d[0][b+2], 8'h33);
`else
        chk_val("t5_we_cnt", we_n[0] - b, 1);
`endif

        // Mode 1: reset during the command, rest of that frame must be ignored
        b = we_n[1]; rb = re_n[1];
        fbegin(1);
        xfer(1, 8'h05, 3, 1'b0, rx);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        xfer(1, 8'hFF, 8, 1'b0, rx);
        xfer(1, 8'h00, 8, 1'b0, rx);
        xfer(1, 8'h55, 8, 1'b0, rx);
        fend(1);
        chk_val("t6_rst_we", we_n[1] - b, 0);
        chk_val("t6_rst_re", re_n[1] - rb, 0);
        fbegin(1);
        xfer(1, 8'h82, 8, 1'b0, rx);
        xfer(1, 8'h40, 8, 1'b0, rx);
        fend(1);
        chk_val("t6_we_cnt", we_n[1] - b, 1);
        chk_val("t6_we_addr", we_a[1][b], 7'h02);
        chk_val("t6_we_data", we_d[1][b], 8'h40);
        chk_val("t6_re_cnt", re_n[1] - rb, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
